// File: rtl/byte_bus_pkg.sv
// Shared types and constants for the 32-bit to 8-bit byte bus bridge.
package byte_bus_pkg;
  localparam int          BYTES_PER_WORD = 4;
  localparam int          IDX_W          = $clog2(BYTES_PER_WORD);
  localparam logic [7:0]  IDLE_CODE_DEF  = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_e;
endpackage

// File: rtl/byte_bus_bridge_if.sv
// Core request/response port plus the 8-bit pin bus, bundled for the bridge.
interface byte_bus_bridge_if #(parameter int WORD_AW = 6);
  logic               req_valid;
  logic               req_write;
  logic [WORD_AW-1:0] req_addr;
  logic [31:0]        req_wdata;
  logic               req_ready;
  logic               rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic [7:0]         data_in;
  logic [7:0]         data_out;
  logic [7:0]         address_out;
  logic               bus_write;
  logic               bus_wait;

  // Bridge side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, data_in, bus_wait,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, data_out, address_out, bus_write
  );

  // Core and host side.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, data_in, bus_wait,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, data_out, address_out, bus_write
  );
endinterface

// File: rtl/byte_lane_shift.sv
// 32-bit word register: full-word load for stores, per-byte write for read
// assembly, and a byte-lane mux that serializes the word onto the pins.
module byte_lane_shift
  import byte_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [31:0]      word_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [7:0]       byte_i,
  output logic [31:0]      word_o,
  output logic [7:0]       byte_o
);
  logic [31:0] word_q;

  // Clear beats load beats byte write; only one is used per cycle anyway.
  always_ff @(posedge clk) begin
    if (rst)         word_q <= '0;
    else if (clr_i)  word_q <= '0;
    else if (load_i) word_q <= word_i;
    else if (we_i)   word_q[8*idx_i +: 8] <= byte_i;
  end

  assign word_o = word_q;
  assign byte_o = word_q[8*idx_i +: 8];
endmodule

// File: rtl/byte_bus_bridge.sv
// Sequences one 32-bit word request into four LSB-first byte phases on the
// 8-bit pin bus; drives the stall code on the address pins when idle.
module byte_bus_bridge
  import byte_bus_pkg::*;
#(
  parameter logic [7:0] IDLE_CODE = IDLE_CODE_DEF,
  parameter int         WORD_AW   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  byte_bus_bridge_if.slave         bus
);
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WORD_AW-1:0] addr_q, addr_d;
  logic               write_q, write_d;
  logic               err_q, err_d;
  logic [7:0]         dout_q;

  logic        clr, load, we, illegal;
  logic [31:0] word;
  logic [7:0]  lane_byte;

  // The last word's top byte address would alias the stall code.
  assign illegal = (8'({bus.req_addr, {IDX_W{1'b1}}}) == IDLE_CODE);

  byte_lane_shift u_lanes (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .load_i (load),
    .word_i (bus.req_wdata),
    .we_i   (we),
    .idx_i  (idx_q),
    .byte_i (bus.data_in),
    .word_o (word),
    .byte_o (lane_byte)
  );

  // State and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  // Holds the last driven store byte so data_out never glitches between stores.
  always_ff @(posedge clk) begin
    if (rst)                  dout_q <= '0;
    else if (state_q == S_WR) dout_q <= lane_byte;
  end

  // Next-state: accept in IDLE, step byte phases unless the host stretches.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    write_d = write_q;
    err_d   = err_q;
    clr     = 1'b0;
    load    = 1'b0;
    we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          write_d = bus.req_write;
          idx_d   = '0;
          err_d   = illegal;
          if (illegal) begin
            clr     = 1'b1;
            state_d = S_RESP;
          end else if (bus.req_write) begin
            load    = 1'b1;
            state_d = S_WR;
          end else begin
            clr     = 1'b1;
            state_d = S_RD;
          end
        end
      end
      S_RD, S_WR: begin
        if (!bus.bus_wait) begin
          we    = (state_q == S_RD);
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(BYTES_PER_WORD - 1)) state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.rsp_err     = (state_q == S_RESP) && err_q;
  assign bus.rsp_rdata   = write_q ? 32'h0 : word;
  assign bus.bus_write   = (state_q == S_WR);
  assign bus.address_out = (state_q == S_RD || state_q == S_WR)
                         ? 8'({addr_q, idx_q}) : IDLE_CODE;
  assign bus.data_out    = (state_q == S_WR) ? lane_byte : dout_q;
endmodule

// File: tb/tb_byte_bus_bridge.sv
// Self-checking bench for byte_bus_bridge: directed cases plus randomized
// transfers checked against a transaction-level host/core model.
module tb_byte_bus_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  byte_bus_bridge_if #(.WORD_AW(6)) bus ();

  byte_bus_bridge #(.IDLE_CODE(8'hFF), .WORD_AW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  // One word transfer. Expected pin activity is derived from the request:
  // byte k of the word goes out at byte address 4*addr+k, each host wait adds
  // a cycle, and the collision word answers with an error and no phases.
  task automatic xfer(input logic wr, input logic [5:0] a, input logic [31:0] wd,
                      input logic [31:0] rw, input int wph, input int wn, input bit rnd);
    logic illegal;
    int   nw;
    illegal = ((a * 4 + 3) == 255);
    chk("idle_ready", bus.req_ready, 1);
    chk("idle_addr", bus.address_out, 8'hFF);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.bus_wait  = 1'($urandom);
    step();
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    if (!illegal) begin
      for (int k = 0; k < 4; k++) begin
        if (k == wph)  nw = wn;
        else if (rnd)  nw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        else           nw = 0;
        for (int w = 0; w <= nw; w++) begin
          chk("ph_addr", bus.address_out, a * 4 + k);
          chk("ph_bus_write", bus.bus_write, wr);
          chk("ph_rsp_valid", bus.rsp_valid, 0);
          if (wr) chk("ph_data_out", bus.data_out, wd[8*k +: 8]);
          bus.bus_wait = (w < nw);
          bus.data_in  = (w < nw) ? 8'($urandom) : rw[8*k +: 8];
          step();
        end
      end
    end
    bus.bus_wait = 1'($urandom);
    bus.data_in  = 8'($urandom);
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_err", bus.rsp_err, illegal);
    if (!wr || illegal) chk("rsp_rdata", bus.rsp_rdata, illegal ? 32'h0 : rw);
    chk("rsp_addr", bus.address_out, 8'hFF);
    chk("rsp_ready", bus.req_ready, 0);
    chk("rsp_bus_write", bus.bus_write, 0);
    step();
    bus.bus_wait = 1'b0;
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("post_ready", bus.req_ready, 1);
    if (wr && !illegal) chk("data_out_hold", bus.data_out, wd[31:24]);
  endtask

  initial begin
    int acc[$];
    int phases;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.data_in   = '0;
    bus.bus_wait  = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_err", bus.rsp_err, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_addr", bus.address_out, 8'hFF);
    chk("rst_bus_write", bus.bus_write, 0);
    rst = 1'b0;
    step();

    // Directed cases.
    xfer(1'b0, 6'd2, 32'h0, 32'hDEADBEEF, -1, 0, 1'b0);
    xfer(1'b1, 6'd1, 32'h8D080004, 32'h0, -1, 0, 1'b0);
    xfer(1'b0, 6'd5, 32'h0, 32'h12345678, 1, 2, 1'b0);
    xfer(1'b0, 6'd63, 32'h0, 32'hA5A5A5A5, -1, 0, 1'b0);
    xfer(1'b1, 6'd63, 32'hCAFEF00D, 32'h0, -1, 0, 1'b0);

    // Reset in the middle of store phase 2 drops the transfer.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 6'd9;
    bus.req_wdata = 32'h44332211;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    chk("mid_addr", bus.address_out, 8'd38);
    chk("mid_data_out", bus.data_out, 8'h33);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_addr", bus.address_out, 8'hFF);
    chk("rstmid_bus_write", bus.bus_write, 0);
    chk("rstmid_ready", bus.req_ready, 1);
    chk("rstmid_data_out", bus.data_out, 0);
    for (int i = 0; i < 4; i++) begin
      chk("rstmid_no_rsp", bus.rsp_valid, 0);
      step();
    end

    // Back-to-back loads with req_valid held: accepts six cycles apart.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 6'd3;
    phases = 0;
    for (int c = 0; c <= 12; c++) begin
      if (bus.req_ready) acc.push_back(c);
      if (bus.address_out != 8'hFF) phases++;
      bus.data_in = 8'($urandom);
      if (c == 12) bus.req_valid = 1'b0;
      step();
    end
    chk("b2b_accepts", acc.size(), 3);
    if (acc.size() == 3) begin
      chk("b2b_gap1", acc[1] - acc[0], 6);
      chk("b2b_gap2", acc[2] - acc[1], 6);
    end
    chk("b2b_phase_cycles", phases, 8);

    // Randomized transfers with random host stretching.
    for (int t = 0; t < 30; t++) begin
      logic [5:0] a;
      a = (t == 7) ? 6'd63 : 6'($urandom);
      xfer(1'($urandom), a, $urandom, $urandom, -1, 0, 1'b1);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
